video_stream_out: RTL and testbench
===================================

// Module: video_stream_out
// PURPOSE
//  Parametrised video output generator: drains pixels from a show-ahead FIFO and produces
//  pixel_out/frame_valid/line_valid with programmable active and blanking periods. Runs on
//  the system clock with a pixel-rate enable (pix_en), so no second clock is sampled.
//  Sits between the output pixel FIFO and the video DAC/encoder; flags FIFO underflow.
// PARAMETERS
//  PIX_W     8    pixel width, bits
//  H_ACTIVE  640  active pixels per line
//  H_BLANK   160  blank pixel periods after each line, except the last line
//  V_ACTIVE  480  active lines per frame
//  V_BLANK   40   blank lines before each frame; one blank line = H_ACTIVE+H_BLANK periods
//  CNT_W     16   width of the pixel-period counters; must hold V_BLANK*(H_ACTIVE+H_BLANK)
// PORTS
//  clk          in   1      system clock
//  nRST         in   1      async active-low reset
//  pix_en       in   1      one-clk pulse per pixel period; all timing advances only on it
//  enable       in   1      start/continue frame generation
//  fifo_data    in   PIX_W  FIFO head word (show-ahead)
//  fifo_empty   in   1      FIFO has no word
//  fifo_rd      out  1      pop; 1-clk pulse, only on a pix_en cycle
//  pixel_out    out  PIX_W  registered pixel
//  frame_valid  out  1      high from first to last active pixel of a frame
//  line_valid   out  1      high during active pixels
//  frame_start  out  1      1-clk pulse with the first active pixel of a frame
//  underflow    out  1      sticky FIFO-underflow flag
//  clr_underflow in  1      clears underflow; a set in the same cycle wins
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; counters 0.
//  - All state, counter and output updates happen on clk edges where pix_en=1.
//    fifo_rd and frame_start are 0 on every other cycle.
//  - Uses an x counter, a y counter and a blank counter. The FSM steps on each pix_en:
//    IDLE:   enable=1 -> VBLANK, blank counter cleared.
//    VBLANK: counts V_BLANK*(H_ACTIVE+H_BLANK) periods. At terminal count:
//            enable=0 -> IDLE; fifo_empty=1 -> hold (counter saturated, frame deferred);
//            else -> ACTIVE with x=0, y=0.
//    ACTIVE: one pixel per period.
//            x==H_ACTIVE-1 and y<V_ACTIVE-1 -> HBLANK.
//            x==H_ACTIVE-1 and y==V_ACTIVE-1 -> VBLANK.
//    HBLANK: H_BLANK periods, then ACTIVE with x=0, y+1.
//  - ACTIVE pixel, FIFO non-empty: fifo_rd=1 on that pix_en clk; pixel_out<=fifo_data;
//    line_valid<=1. Latency: word popped at clk k is on pixel_out from clk k+1.
//  - ACTIVE pixel, FIFO empty: no pop; pixel_out<=0; line_valid stays 1; underflow<=1.
//    Timing is never stretched by an underflow.
//  - frame_valid: set with the first active pixel; held through HBLANK; cleared when
//    VBLANK or IDLE is entered.
//  - Outputs hold their value between pix_en pulses.
//  - enable=0 mid-frame: the current frame completes, then the block returns to IDLE.
//  - nRST mid-line: immediate return to reset values; the next frame starts from a full VBLANK.
// CONFIGURATION
//  VIDEO_STREAM_OUT_TEST_PATTERN_EN
//   defined: adds input test_mode (1 bit). With test_mode=1, ACTIVE pixels are
//   pixel_out = x[PIX_W-1:0] ^ y[PIX_W-1:0]; the FIFO is never read; underflow is not set.
//   The VBLANK end no longer waits on fifo_empty.
//   undefined: no test_mode port; the FIFO path is the only pixel source.
// STRUCTURE
//  package video_out_pkg: state enum {IDLE,VBLANK,ACTIVE,HBLANK}; typedef pixel_t
//  (logic [PIX_W-1:0]); function vblank_periods(H_ACTIVE,H_BLANK,V_BLANK).
//  Sub-module video_timing_cnt: x/y/blank counters with terminal-count outputs, stepped by
//  pix_en. FSM and output registers stay in video_stream_out.
// TESTING (H_ACTIVE=4 H_BLANK=2 V_ACTIVE=3 V_BLANK=1, PIX_W=8)
//  1 FIFO holds 12 words, pix_en=1 every clk, enable=1:
//    6 blank clks, then line_valid = 4 high / 2 low, x3; 12 fifo_rd pulses;
//    pixel_out equals the words in order; frame_start once.
//  2 pix_en every 4th clk:
//    each line_valid pulse lasts 16 clks; fifo_rd only on pix_en clks; 12 pops per frame.
//  3 fifo_empty=1 for the 3rd pixel of line 1:
//    pixel_out=0x00 for that period; line_valid stays 1; underflow=1 until clr_underflow.
//  4 FIFO empty at VBLANK terminal count, filled 5 periods later:
//    frame_valid stays 0; first active pixel is the next pix_en after fifo_empty falls.
//  5 enable dropped during line 2:
//    line 3 completes, then IDLE; no further fifo_rd; frame_valid=0.
//  6 nRST pulsed mid-line:
//    all outputs 0 within the reset; after release, 6 blank periods precede the first pixel.

Source files
------------

// File: rtl/video_out_pkg.sv
// Shared types and helpers for the video output generator.
package video_out_pkg;

  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} state_t;

  localparam int PIX_W_DEFAULT = 8;
  typedef logic [PIX_W_DEFAULT-1:0] pixel_t;

  // One blank line lasts a full line period, active plus horizontal blank.
  function automatic int unsigned vblank_periods(input int unsigned h_active,
                                                 input int unsigned h_blank,
                                                 input int unsigned v_blank);
    return v_blank * (h_active + h_blank);
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// x/y/blank pixel-period counters with terminal-count flags; every update is gated by pix_en.
module video_timing_cnt
  import video_out_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 40
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             pix_en,
  input  logic             x_clr,
  input  logic             x_inc,
  input  logic             y_clr,
  input  logic             y_inc,
  input  logic             b_clr,
  input  logic             b_inc,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             x_last,
  output logic             y_last,
  output logic             hb_last,
  output logic             vb_last
);

  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VB_LAST =
    CNT_W'(vblank_periods(H_ACTIVE, H_BLANK, V_BLANK) - 1);

  logic [CNT_W-1:0] blank;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      x     <= '0;
      y     <= '0;
      blank <= '0;
    end else if (pix_en) begin
      if (x_clr)      x <= '0;
      else if (x_inc) x <= x + 1'b1;
      if (y_clr)      y <= '0;
      else if (y_inc) y <= y + 1'b1;
      // Shared between horizontal and vertical blanking; the FSM clears it on entry.
      if (b_clr)      blank <= '0;
      else if (b_inc) blank <= blank + 1'b1;
    end
  end

  assign x_last  = (x == X_LAST);
  assign y_last  = (y == Y_LAST);
  assign hb_last = (blank == HB_LAST);
  assign vb_last = (blank == VB_LAST);

endmodule

// File: rtl/video_stream_out.sv
// Video output generator: drains a show-ahead FIFO into pixel_out with frame/line timing.
// Optional VIDEO_STREAM_OUT_TEST_PATTERN_EN adds test_mode, an x^y pattern source.
module video_stream_out
  import video_out_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEFAULT,
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 40,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             pix_en,
  input  logic             enable,
  input  logic [PIX_W-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [PIX_W-1:0] pixel_out,
  output logic             frame_valid,
  output logic             line_valid,
  output logic             frame_start,
  output logic             underflow,
  input  logic             clr_underflow
`ifdef VIDEO_STREAM_OUT_TEST_PATTERN_EN
  ,
  input  logic             test_mode
`endif
);

  state_t state, state_nxt;

  logic x_clr, x_inc, y_clr, y_inc, b_clr, b_inc;
  logic x_last, y_last, hb_last, vb_last;
  logic [CNT_W-1:0] x, y;
  logic pattern;
  logic active_pix;
  logic starve;

`ifdef VIDEO_STREAM_OUT_TEST_PATTERN_EN
  assign pattern = test_mode;
`else
  assign pattern = 1'b0;
`endif

  video_timing_cnt #(
    .CNT_W    (CNT_W),
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .V_BLANK  (V_BLANK)
  ) u_cnt (
    .clk     (clk),
    .nRST    (nRST),
    .pix_en  (pix_en),
    .x_clr   (x_clr),
    .x_inc   (x_inc),
    .y_clr   (y_clr),
    .y_inc   (y_inc),
    .b_clr   (b_clr),
    .b_inc   (b_inc),
    .x       (x),
    .y       (y),
    .x_last  (x_last),
    .y_last  (y_last),
    .hb_last (hb_last),
    .vb_last (vb_last)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)       state <= IDLE;
    else if (pix_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    x_clr = 1'b0;
    x_inc = 1'b0;
    y_clr = 1'b0;
    y_inc = 1'b0;
    b_clr = 1'b0;
    b_inc = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = VBLANK;
          b_clr     = 1'b1;
        end
      end
      VBLANK: begin
        // At terminal count the counter saturates until a pixel source is ready.
        if (!vb_last) begin
          b_inc = 1'b1;
        end else if (!enable) begin
          state_nxt = IDLE;
        end else if (!fifo_empty || pattern) begin
          state_nxt = ACTIVE;
          x_clr     = 1'b1;
          y_clr     = 1'b1;
        end
      end
      ACTIVE: begin
        if (!x_last) begin
          x_inc = 1'b1;
        end else begin
          b_clr     = 1'b1;
          state_nxt = y_last ? VBLANK : HBLANK;
        end
      end
      HBLANK: begin
        if (!hb_last) begin
          b_inc = 1'b1;
        end else begin
          state_nxt = ACTIVE;
          x_clr     = 1'b1;
          y_inc     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active_pix = (state == ACTIVE);
  assign starve     = active_pix && fifo_empty && !pattern;
  assign fifo_rd    = pix_en && active_pix && !fifo_empty && !pattern;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pixel_out   <= '0;
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= pix_en && active_pix && (x == '0) && (y == '0);
      if (pix_en) begin
        case (state)
          ACTIVE: begin
            line_valid  <= 1'b1;
            frame_valid <= 1'b1;
            if (pattern)          pixel_out <= x[PIX_W-1:0] ^ y[PIX_W-1:0];
            else if (!fifo_empty) pixel_out <= fifo_data;
            else                  pixel_out <= '0;
          end
          HBLANK:  line_valid <= 1'b0;
          default: begin
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
          end
        endcase
        // Underflow never stretches timing; the slot goes out as zero and is flagged.
        if (starve)             underflow <= 1'b1;
        else if (clr_underflow) underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_out.sv
// Randomised bench for video_stream_out: positional frame model feeds a scoreboard checked every clk.
module tb_video_stream_out;
  import video_out_pkg::*;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VB = 1;
  localparam int LP = HA + HB;
  localparam int NB = VB * LP;
  localparam int FL = NB + VA * LP - HB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nRST, pix_en, enable, fifo_empty, fifo_rd, clr_underflow;
  logic frame_valid, line_valid, frame_start, underflow;
  logic [7:0] fifo_data, pixel_out;
`ifdef VIDEO_STREAM_OUT_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif

  video_stream_out #(
    .PIX_W(8), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CNT_W(16)
  ) dut (
    .clk           (clk),
    .nRST          (nRST),
    .pix_en        (pix_en),
    .enable        (enable),
    .fifo_data     (fifo_data),
    .fifo_empty    (fifo_empty),
    .fifo_rd       (fifo_rd),
    .pixel_out     (pixel_out),
    .frame_valid   (frame_valid),
    .line_valid    (line_valid),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .clr_underflow (clr_underflow)
`ifdef VIDEO_STREAM_OUT_TEST_PATTERN_EN
    ,
    .test_mode     (test_mode)
`endif
  );

  typedef struct packed {
    logic       rd;
    logic       lv;
    logic       fv;
    logic       fs;
    logic       uf;
    logic [7:0] pix;
  } exp_t;

  exp_t   exp_q[$];
  pixel_t fifo_q[$];
  bit     force_empty = 1'b0;
  int     div = 1;
  int     pe_cnt = 0;
  int     checks = 0;
  int     fails = 0;
  int     rd_cnt = 0;
  int     fs_cnt = 0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = force_empty || (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // Bench FIFO pops on the DUT's request, seen before the edge that consumes it.
  task automatic tick();
    logic rd_s;
    @(negedge clk);
    rd_s = fifo_rd;
    @(posedge clk);
    if (rd_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
    pe_cnt++;
    pix_en = (div == 0) ? ($urandom_range(0, 2) == 0) : ((pe_cnt % div) == 0);
    refresh();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input int n);
    repeat (n) fifo_q.push_back(pixel_t'($urandom));
    refresh();
  endtask

  // Reference model: frame position in pixel periods, decoded by plain arithmetic.
  int         m_mode = 0;
  int         m_pos = 0;
  logic       m_lv = 1'b0, m_fv = 1'b0, m_uf = 1'b0;
  logic [7:0] m_pix = 8'h00;

  always @(negedge clk) begin : model
    exp_t e;
    logic set;
    e   = '0;
    set = 1'b0;
    if (!nRST) begin
      m_mode = 0;
      m_pos  = 0;
      m_lv   = 1'b0;
      m_fv   = 1'b0;
      m_uf   = 1'b0;
      m_pix  = 8'h00;
    end else if (pix_en) begin
      if (m_mode == 0) begin
        m_lv = 1'b0;
        m_fv = 1'b0;
        if (enable) begin
          m_mode = 1;
          m_pos  = 0;
        end
      end else if (m_pos < NB) begin
        m_lv = 1'b0;
        m_fv = 1'b0;
        if (m_pos == NB - 1) begin
          if (!enable)          m_mode = 0;
          else if (!fifo_empty) m_pos++;
        end else begin
          m_pos++;
        end
      end else begin
        int q, col;
        q   = m_pos - NB;
        col = q % LP;
        if (col < HA) begin
          m_lv = 1'b1;
          m_fv = 1'b1;
          e.fs = (q == 0);
          if (fifo_empty) begin
            m_pix = 8'h00;
            set   = 1'b1;
          end else begin
            m_pix = fifo_data;
            e.rd  = 1'b1;
          end
        end else begin
          m_lv = 1'b0;
        end
        m_pos++;
        if (m_pos == FL) m_pos = 0;
      end
      m_uf = set ? 1'b1 : (clr_underflow ? 1'b0 : m_uf);
    end
    e.lv  = m_lv;
    e.fv  = m_fv;
    e.uf  = m_uf;
    e.pix = m_pix;
    exp_q.push_back(e);
  end

  initial begin : monitor
    forever begin
      logic rd_now;
      exp_t e;
      @(negedge clk);
      rd_now = fifo_rd;
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (!nRST) begin
          check1("reset_outputs", {fifo_rd, line_valid, frame_valid, frame_start, underflow, pixel_out}, 32'h0);
        end else begin
          check1("fifo_rd", rd_now, e.rd);
          check1("line_valid", line_valid, e.lv);
          check1("frame_valid", frame_valid, e.fv);
          check1("frame_start", frame_start, e.fs);
          check1("underflow", underflow, e.uf);
          if (e.lv) check1("pixel_out", pixel_out, e.pix);
        end
        rd_cnt += int'(rd_now);
        fs_cnt += int'(frame_start);
      end
    end
  end

  initial begin : stimulus
    int rd0, fs0;
    nRST = 1'b0; pix_en = 1'b0; enable = 1'b0; clr_underflow = 1'b0;
    refresh();
    ticks(2);
    check1("reset_state", {line_valid, frame_valid, frame_start, underflow, pixel_out}, 32'h0);
    ticks(1);
    nRST = 1'b1;

    // Full frame at pix_en every clk; enable dropped during line 2.
    rd0 = rd_cnt; fs0 = fs_cnt;
    load(12);
    enable = 1'b1;
    ticks(15);
    enable = 1'b0;
    ticks(30);
    check1("s1_pops", rd_cnt - rd0, 12);
    check1("s1_frame_starts", fs_cnt - fs0, 1);
    check1("s1_idle_fv", frame_valid, 0);

    // pix_en every 4th clk.
    div = 4;
    rd0 = rd_cnt;
    load(12);
    enable = 1'b1;
    ticks(40);
    enable = 1'b0;
    ticks(140);
    check1("s2_pops", rd_cnt - rd0, 12);

    // FIFO starved for the 3rd pixel of the first line.
    div = 1;
    load(12);
    enable = 1'b1;
    ticks(9);
    force_empty = 1'b1; refresh();
    ticks(1);
    force_empty = 1'b0; refresh();
    ticks(3);
    check1("s3_underflow_set", underflow, 1);
    ticks(10);
    enable = 1'b0;
    ticks(20);
    check1("s3_underflow_sticky", underflow, 1);
    clr_underflow = 1'b1;
    ticks(1);
    clr_underflow = 1'b0;
    ticks(1);
    check1("s3_underflow_clr", underflow, 0);
    fifo_q.delete(); refresh();

    // Empty FIFO at the end of vertical blanking defers the frame.
    fs0 = fs_cnt;
    enable = 1'b1;
    ticks(12);
    check1("s4_deferred_fv", frame_valid, 0);
    load(12);
    ticks(3);
    enable = 1'b0;
    ticks(35);
    check1("s4_frame_starts", fs_cnt - fs0, 1);

    // Reset mid-line, then a full blank interval before the first pixel.
    load(12);
    enable = 1'b1;
    ticks(10);
    nRST = 1'b0;
    ticks(1);
    check1("s6_in_reset", {line_valid, frame_valid, underflow, pixel_out}, 32'h0);
    ticks(1);
    nRST = 1'b1;
    ticks(7);
    check1("s6_blank_lv", line_valid, 0);
    ticks(1);
    check1("s6_first_lv", line_valid, 1);
    enable = 1'b0;
    ticks(40);
    clr_underflow = 1'b1;
    ticks(1);
    clr_underflow = 1'b0;
    fifo_q.delete(); refresh();

    // Random pix_en, starvation and clears over several frames.
    div = 0;
    load(30);
    enable = 1'b1;
    repeat (400) begin
      tick();
      if ($urandom_range(0, 15) == 0) force_empty = ~force_empty;
      clr_underflow = ($urandom_range(0, 7) == 0);
      if (fifo_q.size() < 4) load(8);
      refresh();
    end
    enable = 1'b0;
    clr_underflow = 1'b0;
    force_empty = 1'b0;
    refresh();
    ticks(250);
    check1("s7_end_fv", frame_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
